rll_key_sequencer: RTL and testbench
====================================

// Module: rll_key_sequencer
// PURPOSE
// Loads the unlock key for a random-logic-locked combinational netlist from an external key store.
// The key arrives as a chunked valid/ready stream followed by a checksum chunk.
// The key is presented to the netlist's keyIn bus only after the checksum passes, so the netlist never sees a partial key.
// Sits between the secure key store and the locked core; gates the core outputs to 0 until a valid key is applied.
// PARAMETERS
// KEY_W     32    key width; drives keyIn_0_0..keyIn_0_(KEY_W-1); must be a multiple of CHUNK_W
// CHUNK_W   8     key-stream chunk width
// OUT_W     18    width of the locked-core output bus being gated
// TIMEOUT   255   max idle cycles between accepted chunks while loading (>=1)
// MAX_FAIL  3     consecutive failed loads before permanent lockout (>=1)
// PORTS
// clk            in   1        single clock, rising edge
// rst_n          in   1        asynchronous active-low reset
// start          in   1        pulse: begin a key load (honoured in IDLE/ACTIVE/ERROR only)
// clear          in   1        zeroise key, return to IDLE (overrides start)
// kin_valid      in   1        key chunk valid
// kin_ready      out  1        key chunk accepted when kin_valid & kin_ready
// kin_data       in   CHUNK_W  key chunk, LSB chunk first, then checksum chunk
// key_out        out  KEY_W    to core keyIn bus, bit i -> keyIn_0_i
// key_valid      out  1        key_out holds a verified key
// busy           out  1        state is LOAD or CHECK
// err            out  1        sticky: last load failed (checksum or timeout)
// lockout        out  1        MAX_FAIL consecutive failures; only rst_n exits
// ckt_in         in   OUT_W    raw locked-core outputs
// ckt_out        out  OUT_W    registered, gated core outputs
// BEHAVIOUR
// Reset: state=IDLE; key_out=0, key_valid=0, kin_ready=0, busy=0, err=0, lockout=0, ckt_out=0, fail count=0.
// NCHUNK = KEY_W/CHUNK_W. Key chunk k loads shadow[k*CHUNK_W +: CHUNK_W].
// Checksum chunk = XOR of all NCHUNK key chunks.
// States:
//  IDLE:    key_valid=0. start -> LOAD.
//  LOAD:    kin_ready=1. Accepts NCHUNK key chunks, then 1 checksum chunk.
//           Idle counter resets on each accept; TIMEOUT consecutive cycles with no accept -> fail.
//           Checksum chunk accepted -> CHECK.
//  CHECK:   1 cycle. Match -> key_out<=shadow, key_valid=1, err=0, fail count=0 -> ACTIVE.
//           Mismatch -> fail.
//  ACTIVE:  key_out stable. start -> LOAD; key_out/key_valid are held until the new load passes.
//  ERROR:   kin_ready=0. start -> LOAD, err stays 1 until a load passes.
//  LOCKOUT: kin_ready=0, key_out=0, key_valid=0, start/clear ignored.
// fail: err<=1, key_valid<=0, key_out<=0, fail count++.
//  If count reaches MAX_FAIL -> LOCKOUT with lockout=1; else -> ERROR.
// start: entry to LOAD clears the shadow register, chunk index and idle counter.
//  start while busy is ignored.
// clear (any state except LOCKOUT): key_out=0, key_valid=0, shadow=0 -> IDLE next cycle.
//  err and fail count are kept. clear beats a same-cycle start or chunk accept.
// kin_ready is a registered state decode. In the cycle the checksum chunk is accepted, kin_ready drops next cycle.
// ckt_out <= key_valid ? ckt_in : 0. One-cycle latency; it goes 0 the cycle after key_valid falls.
// rst_n asserted mid-load: immediate return to reset values; the partial shadow is discarded.
// TESTING
// Key 0xDEADBEEF: chunks EF,BE,AD,DE,22 -> CHECK passes, key_valid=1, key_out=0xDEADBEEF, err=0.
// Same chunks with checksum 0x23 -> err=1, key_valid=0, key_out=0, state ERROR, kin_ready=0.
// kin_valid low 255 cycles after 2 chunks -> err=1 at timeout, fail count=1.
// 3 consecutive bad loads -> lockout=1; later start and good stream: kin_ready stays 0.
// ACTIVE with key 0xDEADBEEF, reload with 0x01234567 and random kin_valid gaps: key_out stays 0xDEADBEEF until CHECK passes.
// ckt_in=0x3FFFF: ckt_out=0 before key; 0x3FFFF one cycle after key_valid; 0 one cycle after clear.

Source files
------------

// File: rtl/rll_key_sequencer.sv
// rll_key_sequencer
// Streams an unlock key for a logic-locked core in from the key store and
// presents it on key_out only once its checksum has been verified. Until a
// verified key is present, the core's outputs are forced to zero.
module rll_key_sequencer #(
    parameter int KEY_W    = 32,
    parameter int CHUNK_W  = 8,
    parameter int OUT_W    = 18,
    parameter int TIMEOUT  = 255,
    parameter int MAX_FAIL = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear,
    input  logic               kin_valid,
    output logic               kin_ready,
    input  logic [CHUNK_W-1:0] kin_data,
    output logic [KEY_W-1:0]   key_out,
    output logic               key_valid,
    output logic               busy,
    output logic               err,
    output logic               lockout,
    input  logic [OUT_W-1:0]   ckt_in,
    output logic [OUT_W-1:0]   ckt_out
);

    localparam int NCHUNK = KEY_W / CHUNK_W;
    localparam int IDX_W  = $clog2(NCHUNK + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ACTIVE,
        S_ERROR,
        S_LOCKOUT
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [KEY_W-1:0]   shadow;
    logic [IDX_W-1:0]   chunk_idx;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [FAIL_W-1:0]  fail_cnt;
    logic [CHUNK_W-1:0] csum_acc;
    logic               csum_ok;

    logic accept;
    logic do_clear;
    logic last_fail;
    logic pass_evt;
    logic fail_evt;
    logic load_entry;

    assign busy = (state == S_LOAD) || (state == S_CHECK);

    // State register; reset returns to IDLE and drops any partial load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the pass/fail/load-entry events driving the datapath.
    always_comb begin
        next_state = state;
        pass_evt   = 1'b0;
        fail_evt   = 1'b0;
        accept     = (state == S_LOAD) && kin_valid && kin_ready;
        do_clear   = clear && (state != S_LOCKOUT);
        last_fail  = (fail_cnt == FAIL_W'(MAX_FAIL - 1));
        if (do_clear) begin
            next_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) next_state = S_LOAD;
                end
                S_LOAD: begin
                    if (accept && (chunk_idx == IDX_W'(NCHUNK))) begin
                        next_state = S_CHECK;
                    end else if (!accept && (idle_cnt == IDLE_W'(TIMEOUT - 1))) begin
                        fail_evt   = 1'b1;
                        next_state = last_fail ? S_LOCKOUT : S_ERROR;
                    end
                end
                S_CHECK: begin
                    if (csum_ok) begin
                        pass_evt   = 1'b1;
                        next_state = S_ACTIVE;
                    end else begin
                        fail_evt   = 1'b1;
                        next_state = last_fail ? S_LOCKOUT : S_ERROR;
                    end
                end
                S_ACTIVE, S_ERROR: begin
                    if (start) next_state = S_LOAD;
                end
                S_LOCKOUT: begin
                    next_state = S_LOCKOUT;
                end
                default: next_state = S_IDLE;
            endcase
        end
        load_entry = (next_state == S_LOAD) && (state != S_LOAD);
    end

    // Key datapath: shadow capture, checksum tracking, key commit and failure bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kin_ready <= 1'b0;
            ckt_out   <= '0;
            shadow    <= '0;
            chunk_idx <= '0;
            idle_cnt  <= '0;
            csum_acc  <= '0;
            csum_ok   <= 1'b0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
            fail_cnt  <= '0;
            lockout   <= 1'b0;
        end else begin
            kin_ready <= (next_state == S_LOAD);
            ckt_out   <= key_valid ? ckt_in : '0;
            if (do_clear) begin
                key_out   <= '0;
                key_valid <= 1'b0;
                shadow    <= '0;
            end else begin
                if (load_entry) begin
                    shadow    <= '0;
                    chunk_idx <= '0;
                    idle_cnt  <= '0;
                    csum_acc  <= '0;
                end else if (state == S_LOAD) begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (chunk_idx == IDX_W'(NCHUNK)) begin
                            csum_ok <= (kin_data == csum_acc);
                        end else begin
                            for (int k = 0; k < NCHUNK; k++) begin
                                if (chunk_idx == IDX_W'(k)) begin
                                    shadow[k*CHUNK_W +: CHUNK_W] <= kin_data;
                                end
                            end
                            csum_acc  <= csum_acc ^ kin_data;
                            chunk_idx <= chunk_idx + 1'b1;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                if (pass_evt) begin
                    key_out   <= shadow;
                    key_valid <= 1'b1;
                    err       <= 1'b0;
                    fail_cnt  <= '0;
                end
                if (fail_evt) begin
                    key_out   <= '0;
                    key_valid <= 1'b0;
                    err       <= 1'b1;
                    fail_cnt  <= fail_cnt + 1'b1;
                    if (last_fail) lockout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rll_key_sequencer.sv
// tb_rll_key_sequencer
// Directed and randomized key loads against a transaction-level model of the
// sequencer: a load either commits its key or counts one failure.
module tb_rll_key_sequencer;

    localparam int KEY_W    = 32;
    localparam int CHUNK_W  = 8;
    localparam int OUT_W    = 18;
    localparam int TIMEOUT  = 255;
    localparam int MAX_FAIL = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               clear;
    logic               kin_valid;
    logic               kin_ready;
    logic [CHUNK_W-1:0] kin_data;
    logic [KEY_W-1:0]   key_out;
    logic               key_valid;
    logic               busy;
    logic               err;
    logic               lockout;
    logic [OUT_W-1:0]   ckt_in;
    logic [OUT_W-1:0]   ckt_out;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [KEY_W-1:0] exp_key;
    logic             exp_valid;
    logic             exp_err;
    logic             exp_lockout;
    int               exp_fails;

    rll_key_sequencer #(
        .KEY_W(KEY_W), .CHUNK_W(CHUNK_W), .OUT_W(OUT_W),
        .TIMEOUT(TIMEOUT), .MAX_FAIL(MAX_FAIL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .kin_valid(kin_valid), .kin_ready(kin_ready), .kin_data(kin_data),
        .key_out(key_out), .key_valid(key_valid), .busy(busy), .err(err),
        .lockout(lockout), .ckt_in(ckt_in), .ckt_out(ckt_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "/key_out"},   64'(key_out),   64'(exp_key));
        checkValue({tag, "/key_valid"}, 64'(key_valid), 64'(exp_valid));
        checkValue({tag, "/err"},       64'(err),       64'(exp_err));
        checkValue({tag, "/lockout"},   64'(lockout),   64'(exp_lockout));
        checkValue({tag, "/busy"},      64'(busy),      64'd0);
        checkValue({tag, "/kin_ready"}, 64'(kin_ready), 64'd0);
    endtask

    task automatic checkHold();
        checkValue("hold/key_out",   64'(key_out),   64'(exp_key));
        checkValue("hold/key_valid", 64'(key_valid), 64'(exp_valid));
    endtask

    task automatic modelPass(input logic [KEY_W-1:0] key);
        exp_key   = key;
        exp_valid = 1'b1;
        exp_err   = 1'b0;
        exp_fails = 0;
    endtask

    task automatic modelFail();
        exp_key   = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b1;
        exp_fails++;
        if (exp_fails >= MAX_FAIL) exp_lockout = 1'b1;
    endtask

    task automatic modelReset();
        exp_key     = '0;
        exp_valid   = 1'b0;
        exp_err     = 1'b0;
        exp_lockout = 1'b0;
        exp_fails   = 0;
    endtask

    task automatic sendChunk(input logic [CHUNK_W-1:0] d, input int max_gap);
        int gap;
        gap = int'($urandom_range(0, max_gap));
        repeat (gap) begin
            checkHold();
            @(negedge clk);
        end
        kin_valid = 1'b1;
        kin_data  = d;
        for (int n = 0; n < 20 && !kin_ready; n++) begin
            checkHold();
            @(negedge clk);
        end
        checkValue("kin_ready_wait", 64'(kin_ready), 64'd1);
        @(negedge clk);
        kin_valid = 1'b0;
        kin_data  = CHUNK_W'($urandom);
    endtask

    task automatic applyStimulus(input logic [KEY_W-1:0] key, input logic [CHUNK_W-1:0] mask,
                                 input int max_gap);
        logic [CHUNK_W-1:0] cs;
        cs = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < KEY_W / CHUNK_W; k++) begin
            sendChunk(key[k*CHUNK_W +: CHUNK_W], max_gap);
            cs = cs ^ key[k*CHUNK_W +: CHUNK_W];
        end
        sendChunk(cs ^ mask, max_gap);
        checkValue("check/busy",      64'(busy),      64'd1);
        checkValue("check/kin_ready", 64'(kin_ready), 64'd0);
        @(negedge clk);
        if (mask != '0) modelFail();
        else            modelPass(key);
    endtask

    initial begin
        logic [KEY_W-1:0]   rkey;
        logic [OUT_W-1:0]   rin;
        logic [CHUNK_W-1:0] rmask;

        rst_n     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        kin_valid = 1'b0;
        kin_data  = '0;
        ckt_in    = 18'h3FFFF;
        modelReset();

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset");
        checkValue("reset/ckt_out", 64'(ckt_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle");
        checkValue("idle/ckt_out", 64'(ckt_out), 64'd0);

        // Known-good key 0xDEADBEEF, checksum 0x22
        applyStimulus(32'hDEADBEEF, 8'h00, 0);
        checkOutput("deadbeef");
        checkValue("gate/first_cycle", 64'(ckt_out), 64'd0);
        @(negedge clk);
        checkValue("gate/after_valid", 64'(ckt_out), 64'h3FFFF);
        rin    = OUT_W'($urandom);
        ckt_in = rin;
        @(negedge clk);
        checkValue("gate/random_in", 64'(ckt_out), 64'(rin));
        ckt_in = 18'h3FFFF;

        // Reload while ACTIVE with random gaps; old key must be held throughout
        applyStimulus(32'h01234567, 8'h00, 4);
        checkOutput("reload");

        // Clear zeroises the key; gated output falls one cycle later
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_key   = '0;
        exp_valid = 1'b0;
        checkOutput("clear");
        checkValue("clear/ckt_out_lag", 64'(ckt_out), 64'h3FFFF);
        @(negedge clk);
        checkValue("clear/ckt_out_zero", 64'(ckt_out), 64'd0);

        // Bad checksum 0x23 for 0xDEADBEEF
        applyStimulus(32'hDEADBEEF, 8'h01, 0);
        checkOutput("bad_csum");

        // Good load from ERROR clears err and failure count
        applyStimulus(KEY_W'($urandom), 8'h00, 2);
        checkOutput("recover");

        // Timeout after two chunks
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sendChunk(8'hEF, 0);
        sendChunk(8'hBE, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        checkValue("timeout/busy_before", 64'(busy), 64'd1);
        checkValue("timeout/err_before",  64'(err),  64'd0);
        @(negedge clk);
        modelFail();
        checkOutput("timeout");

        // Two more failures reach lockout
        for (int i = 0; i < MAX_FAIL - 1; i++) begin
            rmask = CHUNK_W'($urandom_range(1, 255));
            applyStimulus(KEY_W'($urandom), rmask, 1);
            checkOutput("fail_streak");
        end

        // Lockout ignores start, stream and clear
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        kin_valid = 1'b1;
        kin_data  = 8'hEF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkValue("lockout/kin_ready", 64'(kin_ready), 64'd0);
        end
        kin_valid = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        checkOutput("lockout_hold");

        // Reset is the only exit; then a mid-load reset discards the partial key
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        checkOutput("after_lockout_reset");
        applyStimulus(32'hCAFEF00D, 8'h00, 1);
        checkOutput("pre_midload");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sendChunk(8'h11, 0);
        sendChunk(8'h22, 0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midload_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midload_released");

        // Randomized loads, corrupting only while lockout cannot be reached
        for (int i = 0; i < 8; i++) begin
            rkey  = KEY_W'($urandom);
            rmask = '0;
            if (exp_fails < MAX_FAIL - 1 && $urandom_range(0, 2) == 0)
                rmask = CHUNK_W'($urandom_range(1, 255));
            applyStimulus(rkey, rmask, 3);
            checkOutput("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
